// File: rtl/dmem_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the data-memory arbiter
package mem_arb_pkg;
  localparam int DATA_W_DEF = 48;
  typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_LOAD} owner_e;
  typedef enum logic {S_PIPE, S_FORCE} arb_state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: pipeline, loader and RAM signals around the arbiter
interface dmem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = DATA_W_DEF
);
  logic              p_req, p_we, p_stall, p_rvalid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata, p_rdata;
  logic              l_req, l_we, l_gnt, l_rvalid;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, l_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data, ram_q;
  logic              ram_wren;
  modport slave (
    input  p_req, p_we, p_addr, p_wdata, l_req, l_we, l_addr, l_wdata, ram_q,
    output p_stall, p_rdata, p_rvalid, l_gnt, l_rdata, l_rvalid,
           ram_address, ram_data, ram_wren
  );
  modport master (
    output p_req, p_we, p_addr, p_wdata, l_req, l_we, l_addr, l_wdata, ram_q,
    input  p_stall, p_rdata, p_rvalid, l_gnt, l_rdata, l_rvalid,
           ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of consecutive loader denials with threshold hit
module arb_starve_counter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic deny_i,
  output logic hit_o
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = !deny_i ? 8'd0 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign hit_o = deny_i && ({1'b0, cnt_q} + 9'd1 >= 9'(STARVE_MAX));
  // count register, cleared whenever the loader is granted or idle
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data RAM shared by pipeline (priority) and loader (forced slot)
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  arb_state_e        state_q, state_d;
  owner_e            tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q;
  logic              force_ok, p_gnt, l_gnt, hit;
  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .deny_i(bus.l_req && !l_gnt),
    .hit_o (hit)
  );
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= S_PIPE;
    else      state_q <= state_d;
  // forced slot lasts exactly one cycle after a starvation hit
  always_comb state_d = (state_q == S_PIPE && hit) ? S_FORCE : S_PIPE;
  // grants; a withdrawn loader in S_FORCE falls back to pipeline priority
  always_comb begin
    force_ok = rst && state_q == S_FORCE && bus.l_req;
    l_gnt    = force_ok || (rst && !bus.p_req && bus.l_req);
    p_gnt    = rst && bus.p_req && !force_ok;
    tag_d    = (p_gnt && !bus.p_we) ? OWN_PIPE : (l_gnt && !bus.l_we) ? OWN_LOAD : OWN_NONE;
  end
  // read owner tag and held RAM address
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tag_q  <= OWN_NONE;
      addr_q <= '0;
    end else begin
      tag_q  <= tag_d;
      addr_q <= bus.ram_address;
    end
  assign bus.l_gnt       = l_gnt;
  assign bus.p_stall     = force_ok && bus.p_req;
  assign bus.ram_address = l_gnt ? bus.l_addr : p_gnt ? bus.p_addr : addr_q;
  assign bus.ram_data    = l_gnt ? bus.l_wdata : bus.p_wdata;
  assign bus.ram_wren    = (l_gnt && bus.l_we) || (p_gnt && bus.p_we);
  assign bus.p_rvalid    = tag_q == OWN_PIPE;
  assign bus.l_rvalid    = tag_q == OWN_LOAD;
  assign bus.p_rdata     = bus.p_rvalid ? bus.ram_q : '0;
  assign bus.l_rdata     = bus.l_rvalid ? bus.ram_q : '0;
endmodule
